// File: rtl/aeolus_step_controller_if.sv
// Core-side link of the Aeolus step controller: execute enable and retired count
// towards the core, HALT decode and PC back from it.
interface aeolus_step_controller_if #(
  parameter int PC_W = 4
);
  logic            cpuEn;
  logic [7:0]      instrCount;
  logic            haltReq;
  logic [PC_W-1:0] pc;

  modport master (output cpuEn, output instrCount, input haltReq, input pc);
  modport slave  (input cpuEn, input instrCount, output haltReq, output pc);
endinterface

// File: rtl/aeolus_step_controller.sv
// Aeolus execution sequencer: RUN / single-STEP / HALT control of the core's
// one-cycle execute enable. Breakpoint logic is built only with AEOLUS_BREAKPOINT_EN.
module aeolus_step_controller #(
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 16,
  parameter int PC_W     = 4
) (
  input  logic                       boardCLK,
  input  logic                       reset,
  input  logic                       runSw,
  input  logic                       stepBtn,
  input  logic [PC_W-1:0]            bpAddr,
  input  logic                       bpArm,
  output logic [1:0]                 state,
  output logic                       bpHit,
  aeolus_step_controller_if.master   core
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  localparam logic [7:0]  PRESC_LAST = 8'(DIV - 1);
  localparam logic [15:0] DB_FULL    = 16'(DEBOUNCE);
  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE - 1);

  logic [1:0]  r_state;
  logic        r_cpu_en;
  logic [7:0]  r_count;
  logic [7:0]  r_presc;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_db_cnt;
  logic        r_step_ev;

  logic [1:0]  w_state_nxt;
  logic        w_en_nxt;
  logic [7:0]  w_presc_nxt;
  logic        w_tick;
  logic        w_bp_match;
  logic        w_bp_set;
  logic        w_bp_clr;

  // Step button: 2-FF synchroniser, then a saturating run-length counter that
  // fires a single event on the cycle the run first reaches DEBOUNCE.
  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db_cnt  <= '0;
      r_step_ev <= 1'b0;
    end else begin
      r_sync1   <= stepBtn;
      r_sync2   <= r_sync1;
      r_step_ev <= r_sync2 && (r_db_cnt == DB_LAST);
      if (!r_sync2)
        r_db_cnt <= '0;
      else if (r_db_cnt != DB_FULL)
        r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

`ifdef AEOLUS_BREAKPOINT_EN
  assign w_bp_match = bpArm && (core.pc == bpAddr);
`else
  assign w_bp_match = 1'b0;
`endif

  assign w_tick = (r_presc == PRESC_LAST);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_presc_nxt = '0;
    w_bp_set    = 1'b0;
    w_bp_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (runSw) begin
          w_state_nxt = S_RUN;
        end else if (r_step_ev) begin
          w_state_nxt = S_STEP;
          w_en_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        // Exits drop any tick in flight and leave the prescaler cleared.
        if (core.haltReq) begin
          w_state_nxt = S_HALT;
        end else if (!runSw) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && w_bp_match) begin
          w_state_nxt = S_HALT;
          w_bp_set    = 1'b1;
        end else begin
          w_en_nxt    = w_tick;
          w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
        end
      end
      S_STEP: begin
        w_state_nxt = S_IDLE;
      end
      S_HALT: begin
        if (!runSw) begin
          w_state_nxt = S_IDLE;
          w_bp_clr    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: reset is synchronous and overrides every other input, so a pending pulse is lost.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cpu_en <= 1'b0;
      r_presc  <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_en_nxt;
      r_presc  <= w_presc_nxt;
      r_count  <= r_count + {7'd0, r_cpu_en};
    end
  end

`ifdef AEOLUS_BREAKPOINT_EN
  logic r_bp_hit;

  always_ff @(posedge boardCLK) begin
    if (reset)
      r_bp_hit <= 1'b0;
    else if (w_bp_set)
      r_bp_hit <= 1'b1;
    else if (w_bp_clr)
      r_bp_hit <= 1'b0;
  end

  assign bpHit = r_bp_hit;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{bpAddr, bpArm, core.pc, w_bp_set, w_bp_clr};
  assign bpHit       = 1'b0;
`endif

  assign state           = r_state;
  assign core.cpuEn      = r_cpu_en;
  assign core.instrCount = r_count;

endmodule
